ps2_kbd_matrix: RTL
===================

# ps2_kbd_matrix

PS/2 keyboard receiver and TI-99/2 key-matrix emulator. It deserialises PS/2 frames from the USB/PS2 connector and decodes set-2 make/break codes, including the E0 and F0 prefixes. It holds a 6-column × 8-row pressed-key matrix and answers the CRU keyboard scan combinationally: the CPU drives column-select bits S0–S5 and a row index, and reads one key bit back through the CRUIN multiplexer.

## Interface
Parameters:
- `TMO_BITS`, default 16: width of the frame watchdog counter; a frame aborts after 2^TMO_BITS clocks with no falling PS/2 clock edge (2.6 ms at 25 MHz).

Ports:
- `clk`  in  1: system clock, 25 MHz pixel/CPU clock. One clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `ps2_clk`  in  1: raw PS/2 clock (D+ pin, pulled up), asynchronous.
- `ps2_dat`  in  1: raw PS/2 data (D− pin, pulled up), asynchronous.
- `col`  in  6: column select S5..S0; column c is scanned when `col[c]==0`.
- `row`  in  3: row index (CRU address bits 3:1).
- `kbdout`  out  1: 0 = some scanned key at `row` is pressed; 1 = none.

## Operation
- **Input synchroniser.** `ps2_clk` and `ps2_dat` each pass through 2 flip-flops, resetting to 1.
- **Falling-edge detect.** A third register holds the previous synchronised clock. `fall = prev & !sync`.
- **Frame FSM.** States IDLE, DATA, PARITY, STOP. All transitions happen on `fall`.
  - IDLE → DATA if the sampled data bit is 0 (start bit). A start bit of 1 keeps the FSM in IDLE.
  - DATA shifts 8 bits, LSB first, into `sh[7:0]` using a 3-bit counter, then goes to PARITY.
  - PARITY samples the parity bit, then goes to STOP.
  - STOP goes to IDLE. If stop==1 and the 9 bits (data + parity) have odd parity, `byte_stb` pulses for 1 clk with `sh`. Otherwise the frame is silently dropped.
- **Watchdog.** Counts in any state other than IDLE and clears on every `fall`. At all-ones, the FSM returns to IDLE and partial data is discarded. No byte is emitted.
- **Decoder.** Acts on `byte_stb` and holds flags `ext` (after E0) and `brk` (after F0).
  - `0xE0` sets `ext`.
  - `0xF0` sets `brk`.
  - `0xE1`, `0xAA`, `0xEE`, `0xFA`, `0xFC`, `0xFE`, `0xFF` are ignored and leave the flags unchanged.
  - Any other byte is looked up with {`ext`, code} in a case table giving a 6-bit position {col[2:0], row[2:0]} plus a valid bit. If valid, `key[col*8+row] <= !brk`.
  - After any non-prefix byte, valid or not, both `ext` and `brk` clear.
- **Fake-shift filter.** Codes E0 12 and E0 59 never map; they are always invalid.
- **Mapping table.** The table follows the 99/2 keyboard layout. The following entries are mandatory:
  - 0x16 '1' → c0 r0
  - 0x1C 'A' → c1 r1
  - 0x29 space → c2 r7
  - 0x5A enter → c5 r6
  - 0x12 and 0x59 (L/R shift) → c4 r7
  - E0 75 (up arrow) → c3 r2
  - Unmapped codes → invalid.
- **Read path.** Purely combinational from `key`, `col` and `row`: `kbdout = !OR over c in 0..5 of (!col[c] & key[c*8+row])`. With several columns selected the result is a wired-AND, matching the real matrix. With no column selected, `kbdout=1`.
- **Reset.**
  - `key` = all 0 (all released).
  - FSM = IDLE; `ext` = `brk` = 0; watchdog = 0; synchronisers = 1.
  - `kbdout` = 1 whatever `col` and `row` are.
  - Reset mid-frame aborts the frame; the remaining PS/2 bits are treated as noise until a valid start bit arrives.

## Timing
- **Latency.** `fall` is asserted 3 clk after a raw PS/2 clock falling edge: 2 synchroniser flops plus the edge register.
- **Byte strobe.** `byte_stb` asserts the cycle after the `fall` that samples the stop bit.
- **Matrix update.** `key` updates on the clock edge after `byte_stb`. `kbdout` reflects the change combinationally in that same cycle.
- **End-to-end.** 5 clk from the raw 11th falling edge to `kbdout` change.
- **Read path.** Zero-latency: `kbdout` depends only on registered `key` and the current `col` and `row`, valid within the same cycle as the CRU read.
- **Event rate.** At most one byte per frame (≥ 60 µs apart), so make and break of different keys never coincide.

## Configuration
- `PS2_WATCHDOG_EN` defined: the watchdog counter and abort are implemented as described.
- `PS2_WATCHDOG_EN` undefined: no counter exists and `TMO_BITS` is unused. A truncated frame stays pending until further clock edges complete it. This can leave the FSM bit-misaligned until an invalid parity or stop bit drops a frame.

## Test plan
- **Make A.** Frame 0x1C (parity 0, stop 1); `col`=6'b111101, `row`=1 → `kbdout` goes 1→0 5 clk after the 11th falling edge. With `col`=6'b111110 it stays 1.
- **Break A.** F0 1C → `kbdout` returns to 1. Following bytes decode with `ext`=`brk`=0.
- **Extended key and fake shift.**
  - E0 75 → c3 r2 pressed.
  - E0 12 → c4 r7 stays released.
  - E0 F0 75 → c3 r2 released.
- **Bad parity.** Frame 0x29 with parity bit 1 → dropped; `col`=6'b111011, `row`=7 → `kbdout`=1. The next good 0x29 sets it to 0.
- **Watchdog.** Start bit plus 4 data bits, then `ps2_clk` held high for 2^16 clk, then a full 0x5A frame → c5 r6 pressed. Without `PS2_WATCHDOG_EN`, the same stimulus must not produce c5 r6.
- **Reset.** Keys 0x16 and 0x5A held; assert `reset` for 1 clk mid-frame → all `key`=0 and `kbdout`=1 for every `col`/`row`. A subsequent 0x16 frame → c0 r0 pressed.

Source files
------------

// File: rtl/ps2_kbd_matrix.sv
// ps2_kbd_matrix -- PS/2 keyboard receiver and TI-99/2 key-matrix emulator.
//
// PS/2 set-2 frames are deserialised and make/break codes (including the E0
// and F0 prefixes) update a 6-column x 8-row pressed-key matrix. The CRU
// keyboard scan reads that matrix combinationally.
//
// Ports:
//   clk      in   system clock (25 MHz); all state changes on its rising edge
//   reset    in   synchronous, active-high
//   ps2_clk  in   raw PS/2 clock, asynchronous
//   ps2_dat  in   raw PS/2 data, asynchronous
//   col[5:0] in   column select S5..S0; column c is scanned when col[c]==0
//   row[2:0] in   row index (CRU address bits 3:1)
//   kbdout   out  0 = a scanned key on 'row' is pressed, 1 = none
//
// Parameter TMO_BITS: width of the frame watchdog counter. A frame aborts
// after 2^TMO_BITS clocks without a falling PS/2 clock edge.
//
// Build option: define PS2_WATCHDOG_EN to include the frame watchdog. When it
// is undefined, a truncated frame stays pending until later edges complete it.
module ps2_kbd_matrix #(
  parameter int TMO_BITS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic [5:0] col,
  input  logic [2:0] row,
  output logic       kbdout
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic       clk_s1, clk_s2, clk_prev;
  logic       dat_s1, dat_s2;
  logic       fall;
  state_t     state_q, state_d;
  logic [7:0] sh;
  logic [2:0] cnt;
  logic       par;
  logic       byte_stb, stb_d;
  logic       ext, brk;
  logic [47:0] key;
  logic [5:0] map_pos;
  logic       map_vld;

  // Synchronisers and falling-edge detector. 'fall' is registered so that it
  // lands three clocks after the raw PS/2 clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      fall     <= 1'b0;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat;
      dat_s2   <= dat_s1;
      fall     <= clk_prev & ~clk_s2;
    end
  end

`ifdef PS2_WATCHDOG_EN
  logic [TMO_BITS-1:0] wdog;

  always_ff @(posedge clk) begin
    if (reset || fall || state_q == IDLE)
      wdog <= '0;
    else
      wdog <= wdog + 1'b1;
  end
`else
  // Keeps the parameter referenced when the watchdog is compiled out.
  logic unused_tmo;
  assign unused_tmo = (TMO_BITS > 0);
`endif

  // Frame FSM: next state and stop-bit check.
  always_comb begin
    state_d = state_q;
    stb_d   = 1'b0;
    if (fall) begin
      unique case (state_q)
        IDLE:   if (!dat_s2) state_d = DATA;
        DATA:   if (cnt == 3'd7) state_d = PARITY;
        PARITY: state_d = STOP;
        STOP: begin
          state_d = IDLE;
          // Odd parity over the 8 data bits plus the parity bit.
          stb_d   = dat_s2 & (^{sh, par});
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef PS2_WATCHDOG_EN
    else if (state_q != IDLE && wdog == '1) begin
      state_d = IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sh       <= '0;
      cnt      <= '0;
      par      <= 1'b0;
      byte_stb <= 1'b0;
    end else begin
      state_q  <= state_d;
      byte_stb <= stb_d;
      if (fall) begin
        unique case (state_q)
          IDLE:   cnt <= '0;
          DATA: begin
            sh  <= {dat_s2, sh[7:1]};
            cnt <= cnt + 3'd1;
          end
          PARITY: par <= dat_s2;
          default: ;
        endcase
      end
    end
  end

  // Scan-code to matrix position {col[2:0], row[2:0]}. Extended codes other
  // than those listed never map, so E0 12 / E0 59 (fake shifts) are dropped.
  always_comb begin
    map_pos = '0;
    map_vld = 1'b1;
    unique case ({ext, sh})
      // column 0
      {1'b0, 8'h16}: map_pos = 6'o00;  // 1
      {1'b0, 8'h15}: map_pos = 6'o01;  // Q
      {1'b0, 8'h1E}: map_pos = 6'o02;  // 2
      {1'b0, 8'h1D}: map_pos = 6'o03;  // W
      {1'b0, 8'h26}: map_pos = 6'o04;  // 3
      {1'b0, 8'h24}: map_pos = 6'o05;  // E
      {1'b0, 8'h25}: map_pos = 6'o06;  // 4
      {1'b0, 8'h2D}: map_pos = 6'o07;  // R
      // column 1
      {1'b0, 8'h1A}: map_pos = 6'o10;  // Z
      {1'b0, 8'h1C}: map_pos = 6'o11;  // A
      {1'b0, 8'h22}: map_pos = 6'o12;  // X
      {1'b0, 8'h1B}: map_pos = 6'o13;  // S
      {1'b0, 8'h21}: map_pos = 6'o14;  // C
      {1'b0, 8'h23}: map_pos = 6'o15;  // D
      {1'b0, 8'h2A}: map_pos = 6'o16;  // V
      {1'b0, 8'h2B}: map_pos = 6'o17;  // F
      // column 2
      {1'b0, 8'h2E}: map_pos = 6'o20;  // 5
      {1'b0, 8'h2C}: map_pos = 6'o21;  // T
      {1'b0, 8'h36}: map_pos = 6'o22;  // 6
      {1'b0, 8'h35}: map_pos = 6'o23;  // Y
      {1'b0, 8'h3D}: map_pos = 6'o24;  // 7
      {1'b0, 8'h3C}: map_pos = 6'o25;  // U
      {1'b0, 8'h3E}: map_pos = 6'o26;  // 8
      {1'b0, 8'h29}: map_pos = 6'o27;  // space
      // column 3
      {1'b0, 8'h32}: map_pos = 6'o30;  // B
      {1'b0, 8'h34}: map_pos = 6'o31;  // G
      {1'b1, 8'h75}: map_pos = 6'o32;  // up arrow
      {1'b0, 8'h33}: map_pos = 6'o33;  // H
      {1'b0, 8'h31}: map_pos = 6'o34;  // N
      {1'b0, 8'h3B}: map_pos = 6'o35;  // J
      {1'b0, 8'h3A}: map_pos = 6'o36;  // M
      {1'b0, 8'h42}: map_pos = 6'o37;  // K
      // column 4
      {1'b0, 8'h46}: map_pos = 6'o40;  // 9
      {1'b0, 8'h43}: map_pos = 6'o41;  // I
      {1'b0, 8'h45}: map_pos = 6'o42;  // 0
      {1'b0, 8'h44}: map_pos = 6'o43;  // O
      {1'b0, 8'h55}: map_pos = 6'o44;  // =
      {1'b0, 8'h4D}: map_pos = 6'o45;  // P
      {1'b0, 8'h41}: map_pos = 6'o46;  // ,
      {1'b0, 8'h12}: map_pos = 6'o47;  // left shift
      {1'b0, 8'h59}: map_pos = 6'o47;  // right shift
      // column 5
      {1'b0, 8'h4B}: map_pos = 6'o50;  // L
      {1'b0, 8'h49}: map_pos = 6'o51;  // .
      {1'b0, 8'h4C}: map_pos = 6'o52;  // ;
      {1'b0, 8'h4A}: map_pos = 6'o53;  // /
      {1'b1, 8'h6B}: map_pos = 6'o54;  // left arrow
      {1'b1, 8'h74}: map_pos = 6'o55;  // right arrow
      {1'b0, 8'h5A}: map_pos = 6'o56;  // enter
      {1'b1, 8'h5A}: map_pos = 6'o56;  // keypad enter
      {1'b0, 8'h14}: map_pos = 6'o57;  // left ctrl
      {1'b1, 8'h14}: map_pos = 6'o57;  // right ctrl
      default:       map_vld = 1'b0;
    endcase
  end

  // Make/break decoder.
  always_ff @(posedge clk) begin
    if (reset) begin
      key <= '0;
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (byte_stb) begin
      case (sh)
        8'hE0: ext <= 1'b1;
        8'hF0: brk <= 1'b1;
        8'hE1, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: ;
        default: begin
          if (map_vld) key[map_pos] <= ~brk;
          ext <= 1'b0;
          brk <= 1'b0;
        end
      endcase
    end
  end

  // CRU read path: several selected columns wire-AND on the row line.
  always_comb begin
    logic hit;
    logic [5:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int unsigned c = 0; c < 6; c++) begin
      idx = {3'(c), row};
      hit = hit | (~col[c] & key[idx]);
    end
    kbdout = ~hit;
  end

endmodule
